// File: rtl/fxfl_pkg.sv
// Shared definitions for the fixed/floating add/multiply front end:
// sequencer state encodings, operation select codes and the abort result.
package fxfl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GOT_A     = 3'd1,
    ST_GOT_B     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SHOW      = 3'd5
  } state_t;

  // op_sel is {fixed, mult}
  localparam logic [1:0] OP_FLA = 2'b00;
  localparam logic [1:0] OP_FLM = 2'b01;
  localparam logic [1:0] OP_FIA = 2'b10;
  localparam logic [1:0] OP_FIM = 2'b11;

  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/btn_filter.sv
// Single-button 2-flop synchronizer plus stable-time filter; only used when
// the sequencer is built with BTN_DEBOUNCE_EN.
module btn_filter #(
  parameter logic [19:0] DB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        level_reg;
  logic [19:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= 20'd0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any bounce back to the current level restarts the stable-time count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= 20'd0;
      end else if (cnt_reg >= DB_CYCLES - 20'd1) begin
        level_reg <= sync2_reg;
        cnt_reg   <= 20'd0;
      end else begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/op_sequencer.sv
// Operand/operation sequencer for the add/multiply datapath: captures A, B and
// the op code from button presses, launches the unit and latches its response.
// Define BTN_DEBOUNCE_EN to insert a synchronizer/debounce filter per button.
module op_sequencer
  import fxfl_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [19:0] DB_CYCLES      = 20'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btn_flA,
  input  logic        btn_flM,
  input  logic        btn_fiA,
  input  logic        btn_fiM,
  output logic [15:0] op_num1,
  output logic [15:0] op_num2,
  output logic [1:0]  op_sel,
  output logic        op_start,
  input  logic        op_done,
  input  logic [15:0] op_result,
  input  logic        op_overflow,
  output logic [15:0] result,
  output logic        overflow,
  output logic        timeout,
  output logic        busy,
  output logic [2:0]  state_out
);

  localparam logic [15:0] TERM_COUNT = 16'(TIMEOUT_CYCLES - 1);

  // Bit order: [0] flA, [1] flM, [2] fiA, [3] fiM
  logic [3:0] btn_raw;
  logic [3:0] btn_lvl;

  assign btn_raw = {btn_fiM, btn_fiA, btn_flM, btn_flA};

`ifdef BTN_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_filter
      btn_filter #(
        .DB_CYCLES(DB_CYCLES)
      ) u_btn_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw[gi]),
        .level(btn_lvl[gi])
      );
    end
  endgenerate
`else
  assign btn_lvl = btn_raw;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic        any_btn;
  logic        any_prev_reg;
  logic        press;
  logic [15:0] cnt_reg;
  logic [15:0] num1_reg;
  logic [15:0] num2_reg;
  logic [1:0]  sel_reg;
  logic [15:0] result_reg;
  logic        overflow_reg;
  logic        timeout_reg;
  logic        term_hit;

  assign any_btn  = |btn_lvl;
  assign press    = any_btn & ~any_prev_reg;
  assign term_hit = (cnt_reg == TERM_COUNT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; presses are simply not looked at while busy
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (press) state_next = ST_GOT_A;
      ST_GOT_A:     if (press) state_next = ST_GOT_B;
      ST_GOT_B:     if (press) state_next = ST_ISSUE;
      ST_ISSUE:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (op_done || term_hit) state_next = ST_SHOW;
      ST_SHOW:      if (press) state_next = ST_GOT_A;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Operand, select, wait counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_prev_reg <= 1'b0;
      num1_reg     <= 16'd0;
      num2_reg     <= 16'd0;
      sel_reg      <= OP_FLA;
      cnt_reg      <= 16'd0;
      result_reg   <= 16'd0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      any_prev_reg <= any_btn;
      case (state_reg)
        ST_IDLE, ST_SHOW: if (press) num1_reg <= sw;
        ST_GOT_A:         if (press) num2_reg <= sw;
        ST_GOT_B: begin
          // Plain OR of the held buttons: several at once merge, no priority.
          if (press) sel_reg <= {btn_lvl[2] | btn_lvl[3], btn_lvl[3] | btn_lvl[1]};
        end
        ST_ISSUE: begin
          timeout_reg <= 1'b0;
          cnt_reg     <= 16'd0;
        end
        ST_WAIT_DONE: begin
          // A done in the terminal-count cycle still counts as a completion.
          if (op_done) begin
            result_reg   <= op_result;
            overflow_reg <= op_overflow;
          end else if (term_hit) begin
            result_reg   <= TIMEOUT_RESULT;
            overflow_reg <= 1'b1;
            timeout_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    op_start  = (state_reg == ST_ISSUE);
    busy      = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_DONE);
    state_out = state_reg;
  end

  assign op_num1  = num1_reg;
  assign op_num2  = num2_reg;
  assign op_sel   = sel_reg;
  assign result   = result_reg;
  assign overflow = overflow_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus randomized
// operations scored against a transaction-level model of the sequencer.
module tb_op_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        btn_flA, btn_flM, btn_fiA, btn_fiM;
  logic [15:0] op_num1, op_num2;
  logic [1:0]  op_sel;
  logic        op_start;
  logic        op_done;
  logic [15:0] op_result;
  logic        op_overflow;
  logic [15:0] result;
  logic        overflow;
  logic        timeout;
  logic        busy;
  logic [2:0]  state_out;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] last_res = 16'd0;

  op_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_flA(btn_flA), .btn_flM(btn_flM), .btn_fiA(btn_fiA), .btn_fiM(btn_fiM),
    .op_num1(op_num1), .op_num2(op_num2), .op_sel(op_sel), .op_start(op_start),
    .op_done(op_done), .op_result(op_result), .op_overflow(op_overflow),
    .result(result), .overflow(overflow), .timeout(timeout),
    .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btn_fiM, btn_fiA, btn_flM, btn_flA} = m;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic press_btn(input logic [3:0] m, input logic [15:0] val, input int hold);
    sw = val;
    set_btn(m);
    repeat (hold) tick();
    set_btn(4'b0000);
    tick();
  endtask

  // One full operation. delay = WAIT_DONE cycle (1-based) in which the unit
  // answers; 0 = never answers.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] m, input int delay, input logic [15:0] resp,
                        input logic ovf, input int hold, input bit poke);
    logic        completes;
    logic [1:0]  exp_sel;
    logic [15:0] exp_res;
    int          exp_busy, busy_cnt, starts, widx, guard;
    bit          stable_ok;
    completes = (delay >= 1) && (delay <= TMO);
    exp_sel   = {(m[2] || m[3]), (m[1] || m[3])};  // {any fixed, any multiply}
    exp_res   = completes ? resp : 16'hFFFF;
    exp_busy  = 1 + (completes ? delay : TMO);

    press_btn(m, a, hold);
    chk({tag, " state after A"}, 32'(state_out), 32'd1);
    chk({tag, " op_num1"}, 32'(op_num1), 32'(a));
    chk({tag, " result held"}, 32'(result), 32'(last_res));
    press_btn(m, b, 1);
    chk({tag, " state after B"}, 32'(state_out), 32'd2);
    chk({tag, " op_num2"}, 32'(op_num2), 32'(b));

    sw = 16'($urandom);
    set_btn(m);
    tick();
    set_btn(4'b0000);
    chk({tag, " issue next cycle"}, 32'({state_out, op_start}), 32'({3'd3, 1'b1}));
    chk({tag, " op_sel"}, 32'(op_sel), 32'(exp_sel));

    busy_cnt = 0; starts = 0; widx = 0; guard = 0; stable_ok = 1'b1;
    while (busy && guard < 100) begin
      busy_cnt++;
      if (op_start) starts++;
      if (op_num1 !== a || op_num2 !== b || op_sel !== exp_sel) stable_ok = 1'b0;
      if (state_out == 3'd4) begin
        widx++;
        op_done     = (widx == delay);
        op_result   = op_done ? resp : 16'($urandom);
        op_overflow = ovf;
        if (poke) begin
          sw = 16'($urandom);
          set_btn(widx[0] ? 4'($urandom_range(1, 15)) : 4'b0000);
        end
      end
      tick();
      op_done = 1'b0;
      guard++;
    end
    set_btn(4'b0000);
    if (guard >= 100) begin
      checks++;
      $display("FAIL %s busy_bound: still busy after %0d cycles, required idle", tag, guard);
    end
    chk({tag, " state SHOW"}, 32'(state_out), 32'd5);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, " op_start count"}, 32'(starts), 32'd1);
    chk({tag, " operands stable"}, 32'(stable_ok), 32'd1);
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    chk({tag, " overflow"}, 32'(overflow), 32'(completes ? ovf : 1'b1));
    chk({tag, " timeout"}, 32'(timeout), 32'(!completes));
    last_res = exp_res;
    tick();
  endtask

  task automatic test_reset();
    chk("reset state", 32'(state_out), 32'd0);
    chk("reset operands", 32'({op_num1, op_num2}), 32'd0);
    chk("reset op_sel/start/busy", 32'({op_sel, op_start, busy}), 32'd0);
    chk("reset result", 32'({result, overflow, timeout}), 32'd0);
  endtask

  task automatic test_float_add();
    run_op("flA", 16'h3C00, 16'h3C00, 4'b0001, 1, 16'h4000, 1'b0, 1, 1'b0);
  endtask

  task automatic test_fixed_mult_overflow();
    run_op("fiM", 16'h7FFF, 16'h0002, 4'b1000, 5, 16'h0000, 1'b1, 1, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("timeout", 16'h1234, 16'h5678, 4'b0100, 0, 16'h0BAD, 1'b0, 1, 1'b0);
  endtask

  task automatic test_held_press();
    run_op("held", 16'hA5A5, 16'h0F0F, 4'b0010, 7, 16'h2468, 1'b0, 10, 1'b1);
  endtask

  task automatic test_simultaneous();
    run_op("simul", 16'h1111, 16'h2222, 4'b0110, TMO, 16'h3333, 1'b0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom),
             4'($urandom_range(1, 15)), int'($urandom_range(0, TMO + 2)),
             16'($urandom), 1'($urandom), int'($urandom_range(1, 4)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    press_btn(4'b0001, 16'hBEEF, 1);
    press_btn(4'b0001, 16'hCAFE, 1);
    press_btn(4'b1000, 16'h0000, 1);
    tick();
    tick();
    chk("mid busy before reset", 32'({state_out, busy}), 32'({3'd4, 1'b1}));
    #2 rst = 1'b0;
    #1;
    chk("mid reset state", 32'(state_out), 32'd0);
    chk("mid reset result/busy", 32'({result, busy}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    op_done = 1'b1;
    op_result = 16'h7777;
    op_overflow = 1'b1;
    tick();
    op_done = 1'b0;
    chk("late done state", 32'(state_out), 32'd0);
    chk("late done result", 32'({result, overflow}), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    sw = 16'd0;
    set_btn(4'b0000);
    op_done = 1'b0;
    op_result = 16'd0;
    op_overflow = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_float_add();
    test_fixed_mult_overflow();
    test_timeout();
    test_held_press();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
